// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard controller for the 5-stage MIPS pipeline.
//   - Forwarding selects for the execute-stage ALU operands (ForwardAE/BE)
//     and the decode-stage branch comparator (ForwardAD/BD).
//   - Load-use and branch-operand stalls with the matching decode->execute
//     clear (FlushE) and the taken-branch fetch->decode clear (FlushD).
//   - Data-memory wait FSM (RUN/WAIT/ERR).  While a memory access in M is
//     not ready, every stage is held and nothing is flushed, so no
//     instruction is lost.  After MEM_TIMEOUT consecutive not-ready cycles
//     the FSM traps in ERR, freezing the pipeline until reset.
//   - Saturating performance counters of stall and flush cycles.
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   RsD/RtD, RsE/RtE          source registers in decode / execute
//   WriteRegE/M/W, RegWriteE/M/W  destination register and write enable
//   MemtoRegE/M               load instruction in E / M
//   BranchD, PCSrcD           branch in decode, branch taken
//   MemReqM, MemReadyM        data-memory request in M, completion
//   cnt_clr                   synchronous clear of both counters
//   StallF..StallW            hold stage registers
//   FlushD, FlushE            clear fetch->decode / decode->execute regs
//   ForwardAD/BD              branch comparator operand from ALUOutM
//   ForwardAE/BE              00 regfile, 01 WB result, 10 ALUOutM
//   mem_timeout               sticky trap flag
//   stall_cnt, flush_cnt      saturating performance counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             PCSrcD,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  input  logic             cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

  localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t         state, state_next;
  logic [WCW-1:0] wait_cnt, wait_cnt_next;
  logic           lwstall, brstall, hstall;
  logic           mem_pending, freeze;

  // Register $0 is hard-wired to zero, so it never forwards.
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst,
                                     input logic we);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (reg_match(RsE, WriteRegM, RegWriteM))      ForwardAE = 2'b10;
    else if (reg_match(RsE, WriteRegW, RegWriteW)) ForwardAE = 2'b01;
    if (reg_match(RtE, WriteRegM, RegWriteM))      ForwardBE = 2'b10;
    else if (reg_match(RtE, WriteRegW, RegWriteW)) ForwardBE = 2'b01;
    ForwardAD = reg_match(RsD, WriteRegM, RegWriteM);
    ForwardBD = reg_match(RtD, WriteRegM, RegWriteM);
  end

  always_comb begin
    lwstall = MemtoRegE && (RtE != 5'd0) && ((RtE == RsD) || (RtE == RtD));
    // A branch resolved in decode needs its operands now: stall while the
    // producer is still in E, or is a load whose data is not out of M yet.
    brstall = BranchD &&
              ((RegWriteE && (WriteRegE != 5'd0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
               (MemtoRegM && (WriteRegM != 5'd0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    hstall      = lwstall || brstall;
    mem_pending = MemReqM && !MemReadyM;
    freeze      = (state == ERR) || mem_pending;
  end

  // A freeze holds every stage and suppresses flushes so that the load-use
  // bubble or branch redirect is re-evaluated once the memory completes.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    StallW = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (!rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else begin
        StallF = hstall;
        StallD = hstall;
        FlushE = hstall;
        FlushD = PCSrcD && !hstall;
      end
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      RUN: begin
        if (mem_pending) begin
          state_next    = (MEM_TIMEOUT == 1) ? ERR : WAIT;
          wait_cnt_next = WCW'(1);
        end
      end
      WAIT: begin
        if (!mem_pending) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if ((MEM_TIMEOUT != 0) && (int'(wait_cnt) + 1 == MEM_TIMEOUT)) begin
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt + WCW'(1);
        end
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= state_next;
      wait_cnt    <= wait_cnt_next;
      mem_timeout <= (state_next == ERR);
      if (cnt_clr) begin
        stall_cnt <= '0;
        flush_cnt <= '0;
      end else begin
        if (StallD) stall_cnt <= sat_inc(stall_cnt);
        if (FlushE) flush_cnt <= sat_inc(flush_cnt);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD;
  logic MemReqM, MemReadyM, cnt_clr;
  logic StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, ForwardAD, ForwardBD;
  logic [1:0] ForwardAE, ForwardBE;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [4:0] stall_v;

  assign stall_v = {StallF, StallD, StallE, StallM, StallW};

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .PCSrcD(PCSrcD),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .cnt_clr(cnt_clr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
    .FlushD(FlushD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       rwe, rwm, rww, m2re, m2rm, br, pcs;
    logic [4:0] stall;
    logic       fd, fe, fad, fbd;
    logic [1:0] fae, fbe;
  } vec_t;

  vec_t vecs[13];
  vec_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PCSrcD = 0;
    MemReqM = 0; MemReadyM = 0; cnt_clr = 0;
  endtask

  task automatic drive(input vec_t v);
    RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
    WriteRegE = v.wre; WriteRegM = v.wrm; WriteRegW = v.wrw;
    RegWriteE = v.rwe; RegWriteM = v.rwm; RegWriteW = v.rww;
    MemtoRegE = v.m2re; MemtoRegM = v.m2rm; BranchD = v.br; PCSrcD = v.pcs;
    sb_q.push_back(v);
  endtask

  task automatic check_sb(input int idx);
    vec_t e;
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", idx), 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("v%0d_stall", idx), 32'(stall_v), 32'(e.stall));
      chk($sformatf("v%0d_FlushD", idx), 32'(FlushD), 32'(e.fd));
      chk($sformatf("v%0d_FlushE", idx), 32'(FlushE), 32'(e.fe));
      chk($sformatf("v%0d_ForwardAD", idx), 32'(ForwardAD), 32'(e.fad));
      chk($sformatf("v%0d_ForwardBD", idx), 32'(ForwardBD), 32'(e.fbd));
      chk($sformatf("v%0d_ForwardAE", idx), 32'(ForwardAE), 32'(e.fae));
      chk($sformatf("v%0d_ForwardBE", idx), 32'(ForwardBE), 32'(e.fbe));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Field order: rsd rtd rse rte wre wrm wrw | rwe rwm rww m2re m2rm br pcs |
    //              stall{F,D,E,M,W} fd fe fad fbd fae fbe
    vecs[0]  = '{0,0,0,0,0,0,0, 0,0,0,0,0,0,0, 5'b00000,0,0,0,0,2'b00,2'b00};
    // lw $2 in E, add $3,$2,$4 in D
    vecs[1]  = '{2,4,0,2,2,0,0, 1,0,0,1,0,0,0, 5'b11000,0,1,0,0,2'b00,2'b00};
    // $5 written in M and W, RsE=5: M wins
    vecs[2]  = '{0,0,5,0,0,5,5, 0,1,1,0,0,0,0, 5'b00000,0,0,0,0,2'b10,2'b00};
    // only W writes $5
    vecs[3]  = '{0,0,5,0,0,0,5, 0,0,1,0,0,0,0, 5'b00000,0,0,0,0,2'b01,2'b00};
    // writes to $0 never forward
    vecs[4]  = '{0,0,0,0,0,0,0, 0,1,1,0,0,0,0, 5'b00000,0,0,0,0,2'b00,2'b00};
    // M matches RtE but RegWriteM=0 -> falls through to W
    vecs[5]  = '{0,0,0,7,0,7,7, 0,0,1,0,0,0,0, 5'b00000,0,0,0,0,2'b00,2'b01};
    // beq $6 in D, E writes $6 -> stall, taken branch flush suppressed
    vecs[6]  = '{6,1,0,0,6,0,0, 1,0,0,0,0,1,1, 5'b11000,0,1,0,0,2'b00,2'b00};
    // next cycle M writes $6 -> forward to comparator, taken -> FlushD
    vecs[7]  = '{6,1,0,0,0,6,0, 0,1,0,0,0,1,1, 5'b00000,1,0,1,0,2'b00,2'b00};
    // branch on $9 while a load of $9 is in M -> stall
    vecs[8]  = '{0,9,0,0,0,9,0, 0,1,0,0,1,1,0, 5'b11000,0,1,0,1,2'b00,2'b00};
    // load into $0 in E never causes a load-use stall
    vecs[9]  = '{0,0,0,0,0,0,0, 1,0,0,1,0,0,0, 5'b00000,0,0,0,0,2'b00,2'b00};
    // load $3 in E, D reads $3 through Rt
    vecs[10] = '{1,3,0,3,3,0,0, 1,0,0,1,0,0,0, 5'b11000,0,1,0,0,2'b00,2'b00};
    // branch on $0 with E writing $0: no stall, taken -> FlushD
    vecs[11] = '{0,0,0,0,0,0,0, 1,0,0,0,0,1,1, 5'b00000,1,0,0,0,2'b00,2'b00};
    // $4 in M and W, every source reads $4
    vecs[12] = '{4,4,4,4,0,4,4, 0,1,1,0,0,0,0, 5'b00000,0,0,1,1,2'b10,2'b10};

    // Reset: outputs quiet even with a load-use hazard on the inputs
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2;
    #2;
    chk("rst_stall", 32'(stall_v), 0);
    chk("rst_FlushE", 32'(FlushE), 0);
    chk("rst_mem_timeout", 32'(mem_timeout), 0);
    chk("rst_stall_cnt", 32'(stall_cnt), 0);
    chk("rst_flush_cnt", 32'(flush_cnt), 0);
    @(negedge clk);
    clear_inputs();
    rst = 0;

    // Table-driven combinational checks
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_sb(i);
    end

    // One load-use stall cycle counts once in each counter
    @(negedge clk);
    clear_inputs();
    cnt_clr = 1;
    @(negedge clk);
    cnt_clr = 0;
    chk("clr_stall_cnt", 32'(stall_cnt), 0);
    chk("clr_flush_cnt", 32'(flush_cnt), 0);
    drive(vecs[1]);
    #1;
    check_sb(101);
    @(negedge clk);
    clear_inputs();
    chk("lw_stall_cnt", 32'(stall_cnt), 1);
    chk("lw_flush_cnt", 32'(flush_cnt), 1);
    @(negedge clk);
    chk("idle_stall_cnt", 32'(stall_cnt), 1);

    // Memory not ready for 3 cycles while a load-use hazard is present
    drive(vecs[1]);
    void'(sb_q.pop_back());
    MemReqM = 1; MemReadyM = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("wait%0d_stall", c), 32'(stall_v), 32'h1f);
      chk($sformatf("wait%0d_FlushE", c), 32'(FlushE), 0);
      @(negedge clk);
    end
    MemReadyM = 1;
    #1;
    chk("ready_stall", 32'(stall_v), 32'h18);
    chk("ready_FlushE", 32'(FlushE), 1);
    @(negedge clk);
    clear_inputs();
    MemReqM = 1; MemReadyM = 1;
    #1;
    chk("zero_lat_stall", 32'(stall_v), 0);
    chk("no_trap", 32'(mem_timeout), 0);

    // Timeout: ready held low traps after the 4th edge
    @(negedge clk);
    MemReqM = 1; MemReadyM = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to_edge%0d", k), 32'(mem_timeout), (k == 4) ? 1 : 0);
    end
    MemReqM = 0; PCSrcD = 1;
    #1;
    chk("err_stall", 32'(stall_v), 32'h1f);
    chk("err_FlushD", 32'(FlushD), 0);
    @(negedge clk);
    chk("err_sticky", 32'(mem_timeout), 1);
    #2 rst = 1;
    #1;
    chk("async_rst_trap", 32'(mem_timeout), 0);
    chk("async_rst_stall", 32'(stall_v), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("resume_stall", 32'(stall_v), 0);
    chk("resume_FlushD", 32'(FlushD), 1);
    chk("resume_trap", 32'(mem_timeout), 0);

    // Counter saturation: 2^CNT_W+3 stall cycles
    clear_inputs();
    drive(vecs[1]);
    void'(sb_q.pop_back());
    repeat ((1 << CNT_W) + 3) @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), (1 << CNT_W) - 1);
    chk("sat_flush_cnt", 32'(flush_cnt), (1 << CNT_W) - 1);
    cnt_clr = 1;
    @(negedge clk);
    chk("clr_wins_stall", 32'(stall_cnt), 0);
    chk("clr_wins_flush", 32'(flush_cnt), 0);
    cnt_clr = 0;
    @(negedge clk);
    chk("post_clr_stall", 32'(stall_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
